// File: rtl/shift_reg_pkg.sv
// Shared definitions for the shift-register family (PIPO / PISO / SIPO).
// Contents:
//   BIT_ORDER_MSB / BIT_ORDER_LSB : serial bit-order selectors
//   cnt_width()                   : counter width needed to count 0..n-1
package shift_reg_pkg;

    localparam bit BIT_ORDER_MSB = 1'b1;
    localparam bit BIT_ORDER_LSB = 1'b0;

    // Smallest w >= 1 with 2**w >= n. The loop is bounded, so it elaborates as a constant.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = 32'd1;
        for (int unsigned i = 32'd1; i < 32'd32; i++) begin
            if ((32'd1 << i) < n) begin
                w = i + 32'd1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/pipo_hold_reg.sv
// Parallel-in parallel-out holding register with a valid flag.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   load, d         : capture d into q when load is high
//   set_valid       : raise valid (wins over clr_valid)
//   clr_valid       : drop valid
//   q, valid        : registered word and its valid flag
module pipo_hold_reg #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             set_valid,
    input  logic             clr_valid,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    logic [WIDTH-1:0] data_r;
    logic             valid_r;

    // Data register: only changes on an explicit load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r <= '0;
        end else if (load) begin
            data_r <= d;
        end
    end

    // Valid flag: set has priority so a reload during a drain keeps the word valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
        end else if (set_valid) begin
            valid_r <= 1'b1;
        end else if (clr_valid) begin
            valid_r <= 1'b0;
        end
    end

    assign q     = data_r;
    assign valid = valid_r;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out deserializer with a valid/ready output holding register.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   sin, sin_valid    : serial bit and its qualifier
//   clr               : synchronous flush of partial word and overrun flag
//   q, q_valid        : completed word, held until q_ready handshake
//   q_ready           : consumer accept
//   bit_cnt           : bits collected in the current partial word
//   overrun           : sticky, a completed word was dropped (holding reg full)
module sipo_deserializer
    import shift_reg_pkg::*;
#(
    parameter int unsigned  WIDTH     = 4,
    parameter bit           MSB_FIRST = BIT_ORDER_MSB,
    localparam int unsigned CNT_W     = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    logic [WIDTH-1:0] sh_r;
    logic [CNT_W-1:0] cnt_r;
    logic             overrun_r;

    logic [WIDTH-1:0] word_s;
    logic             sample_s;
    logic             last_s;
    logic             can_load_s;
    logic             load_s;
    logic             drop_s;
    logic             drain_s;

    // clr discards a bit presented in the same cycle.
    assign sample_s   = sin_valid && !clr;
    assign last_s     = sample_s && (cnt_r == CNT_LAST);
    // The holding register is free if empty or being emptied at this very edge.
    assign can_load_s = !q_valid || q_ready;
    assign load_s     = last_s && can_load_s;
    assign drop_s     = last_s && !can_load_s;
    assign drain_s    = q_valid && q_ready;

    // Shift register contents after accepting sin, in the configured bit order.
    always_comb begin
        if (MSB_FIRST == BIT_ORDER_MSB) begin
            word_s = {sh_r[WIDTH-2:0], sin};
        end else begin
            word_s = {sin, sh_r[WIDTH-1:1]};
        end
    end

    // Shift register: flushed by clr, shifts on each sampled bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_r <= '0;
        end else if (clr) begin
            sh_r <= '0;
        end else if (sample_s) begin
            sh_r <= word_s;
        end
    end

    // Bit counter: wraps on the final bit whether or not the word is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (sample_s) begin
            cnt_r <= last_s ? '0 : (cnt_r + CNT_ONE);
        end
    end

    // Sticky overrun: set when a completed word finds the holding register full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_r <= 1'b0;
        end else if (clr) begin
            overrun_r <= 1'b0;
        end else if (drop_s) begin
            overrun_r <= 1'b1;
        end
    end

    // The completed word goes straight from the shift path into the output stage.
    pipo_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .d         (word_s),
        .set_valid (load_s),
        .clr_valid (drain_s),
        .q         (q),
        .valid     (q_valid)
    );

    assign bit_cnt = cnt_r;
    assign overrun = overrun_r;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench: one MSB-first and one LSB-first instance share stimulus;
// expected words are queued at issue and popped by a monitor at each handshake.
module tb_sipo_deserializer;

    logic       clk = 1'b0;
    logic       rst, sin, sin_valid, clr, q_ready;
    logic [3:0] q_m, q_l;
    logic       qv_m, qv_l, ov_m, ov_l;
    logic [1:0] cnt_m, cnt_l;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_m[$];
    logic [3:0] exp_l[$];

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .clr(clr),
        .q(q_m), .q_valid(qv_m), .q_ready(q_ready), .bit_cnt(cnt_m), .overrun(ov_m)
    );

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .clr(clr),
        .q(q_l), .q_valid(qv_l), .q_ready(q_ready), .bit_cnt(cnt_l), .overrun(ov_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: a word is consumed at the next posedge whenever valid && ready here.
    always @(negedge clk) begin
        if (!rst && q_ready) begin
            if (qv_m) begin
                if (exp_m.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_msb unexpected word actual %b required none", q_m);
                end else begin
                    check("sb_msb", 32'(q_m), 32'(exp_m.pop_front()));
                end
            end
            if (qv_l) begin
                if (exp_l.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_lsb unexpected word actual %b required none", q_l);
                end else begin
                    check("sb_lsb", 32'(q_l), 32'(exp_l.pop_front()));
                end
            end
        end
    end

    // Tasks start and end 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sin = b;
        sin_valid = 1'b1;
        tick();
        sin_valid = 1'b0;
    endtask

    // v[3] is sent first.
    task automatic send4(input logic [3:0] v);
        for (int i = 3; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic expect_word(input logic [3:0] m, input logic [3:0] l);
        exp_m.push_back(m);
        exp_l.push_back(l);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; clr = 1'b0; q_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_q",       32'(q_m),   32'h0);
        check("rst_qvalid",  32'(qv_m),  32'h0);
        check("rst_cnt",     32'(cnt_m), 32'h0);
        check("rst_overrun", 32'(ov_m),  32'h0);

        // Asynchronous reset mid-word after 2 bits.
        send_bit(1'b1); send_bit(1'b0);
        check("pre_rst_cnt", 32'(cnt_m), 32'h2);
        #3 rst = 1'b1;
        #1;
        check("async_rst_cnt",    32'(cnt_m), 32'h0);
        check("async_rst_cnt_l",  32'(cnt_l), 32'h0);
        check("async_rst_qvalid", 32'(qv_m),  32'h0);
        check("async_rst_q",      32'(q_m),   32'h0);
        check("async_rst_ovr",    32'(ov_m),  32'h0);
        tick();
        rst = 1'b0;

        // Consecutive bits 1,0,0,1 with q_ready high.
        expect_word(4'b1001, 4'b1001);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        check("t2_qvalid_early", 32'(qv_m), 32'h0);
        send_bit(1'b1);
        check("t2_qvalid",   32'(qv_m), 32'h1);
        check("t2_qvalid_l", 32'(qv_l), 32'h1);
        check("t2_q",        32'(q_m),  32'h9);
        tick();
        check("t2_qvalid_one_cycle", 32'(qv_m), 32'h0);

        // Gapped input 1,idle,0,idle,1,1.
        expect_word(4'b1011, 4'b1101);
        check("t3_cnt0", 32'(cnt_m), 32'h0);
        send_bit(1'b1); check("t3_cnt1", 32'(cnt_m), 32'h1);
        tick();         check("t3_cnt2", 32'(cnt_m), 32'h1);
        send_bit(1'b0); check("t3_cnt3", 32'(cnt_m), 32'h2);
        tick();         check("t3_cnt4", 32'(cnt_m), 32'h2);
        send_bit(1'b1); check("t3_cnt5", 32'(cnt_m), 32'h3);
        send_bit(1'b1); check("t3_cnt6", 32'(cnt_m), 32'h0);
        check("t3_q_lsb", 32'(q_l), 32'hD);
        tick();

        // Bit order check with 1,1,0,0.
        expect_word(4'b1100, 4'b0011);
        send4(4'b1100);
        check("t3b_q_lsb", 32'(q_l), 32'h3);
        tick();

        // Backpressure: second word is dropped.
        q_ready = 1'b0;
        expect_word(4'b1001, 4'b1001);
        send4(4'b1001);
        check("t4_qvalid",      32'(qv_m), 32'h1);
        check("t4_ovr_before",  32'(ov_m), 32'h0);
        send4(4'b0110);
        check("t4_q_held",      32'(q_m),  32'h9);
        check("t4_q_held_l",    32'(q_l),  32'h9);
        check("t4_qvalid_held", 32'(qv_m), 32'h1);
        check("t4_overrun",     32'(ov_m), 32'h1);
        check("t4_overrun_l",   32'(ov_l), 32'h1);
        check("t4_cnt_wrap",    32'(cnt_m), 32'h0);
        q_ready = 1'b1;
        tick();
        q_ready = 1'b0;
        check("t4_drained",      32'(qv_m), 32'h0);
        check("t4_overrun_kept", 32'(ov_m), 32'h1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t4_clr_ovr",   32'(ov_m), 32'h0);
        check("t4_clr_ovr_l", 32'(ov_l), 32'h0);

        // Completion coinciding with a handshake.
        expect_word(4'b1001, 4'b1001);
        send4(4'b1001);
        expect_word(4'b0110, 4'b0110);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        q_ready = 1'b1;
        send_bit(1'b0);
        q_ready = 1'b0;
        check("t5_qvalid", 32'(qv_m), 32'h1);
        check("t5_q",      32'(q_m),  32'h6);
        check("t5_ovr",    32'(ov_m), 32'h0);
        check("t5_ovr_l",  32'(ov_l), 32'h0);

        // clr mid-word with a pending word; the bit during clr is discarded.
        send_bit(1'b1); send_bit(1'b1);
        check("t6_cnt_pre", 32'(cnt_m), 32'h2);
        clr = 1'b1; sin = 1'b1; sin_valid = 1'b1;
        tick();
        clr = 1'b0; sin_valid = 1'b0;
        check("t6_cnt_clr",   32'(cnt_m), 32'h0);
        check("t6_cnt_clr_l", 32'(cnt_l), 32'h0);
        check("t6_qvalid",    32'(qv_m),  32'h1);
        check("t6_q",         32'(q_m),   32'h6);
        q_ready = 1'b1;
        tick();
        expect_word(4'b0111, 4'b1110);
        send4(4'b0111);
        check("t6_q_new",   32'(q_m), 32'h7);
        check("t6_q_new_l", 32'(q_l), 32'hE);
        tick();
        tick();

        check("sb_msb_drained", 32'(exp_m.size()), 32'h0);
        check("sb_lsb_drained", 32'(exp_l.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Serial-in, parallel-out deserializer with an output holding register and a valid/ready handshake.
- Collects WIDTH serial bits qualified by sin_valid, in the configured bit order.
- Presents each completed word on q with q_valid and holds it until the consumer accepts it.
- Serves as the receive end of the shift-register family: it turns a bit stream back into the parallel words that the PIPO/PISO stages carry.

Parameters:
WIDTH, 4, word width in bits (legal range 2..32)
MSB_FIRST, 1, 1: first received bit lands in q[WIDTH-1]; 0: first received bit lands in q[0]

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst  input  1  reset, asynchronous, active-high; clears all state immediately
sin  input  1  serial data bit
sin_valid  input  1  sin is sampled at this rising edge only when high
clr  input  1  synchronous flush of the partial word and of the overrun flag
q  output  WIDTH  completed parallel word
q_valid  output  1  q holds an unconsumed word
q_ready  input  1  consumer accepts q at a rising edge where q_valid && q_ready
bit_cnt  output  CNT_W  bits collected in the current partial word, 0..WIDTH-1; CNT_W = clog2(WIDTH)
overrun  output  1  sticky: a completed word was dropped because the holding register was full

Behaviour:
- Reset (rst=1, asynchronous): q=0, q_valid=0, bit_cnt=0, overrun=0, shift register=0. An asserted reset mid-word discards the partial word. There is no partial state after release.
- Shift, MSB_FIRST=1: on sin_valid, sh <= {sh[WIDTH-2:0], sin}.
- Shift, MSB_FIRST=0: on sin_valid, sh <= {sin, sh[WIDTH-1:1]}.
- Counter: on sin_valid, bit_cnt increments. At bit_cnt==WIDTH-1 it wraps to 0 and the word completes.
- Completion: the assembled word (sh plus the final sin) is written directly into q at the edge that samples the final bit. The shift register is not re-read later.
  - Latency: q_valid is high in the cycle after the final-bit edge.
- Loading the holding register: load is allowed when q_valid==0, or when q_valid && q_ready at that same edge.
  - Simultaneous completion and handshake: the new word replaces the old one, q_valid stays 1, no overrun.
- Dropping a word: on completion with q_valid=1 and q_ready=0, the new word is discarded. q keeps the old word and overrun <= 1. The counter still wraps to 0.
- Draining: on q_valid && q_ready with no completion, q_valid <= 0. q keeps its value; contents are don't-care while q_valid=0.
- clr: sets bit_cnt=0, sh=0, overrun=0.
  - clr has priority over sin_valid in the same cycle; that bit is discarded.
  - clr does not touch q or q_valid; a pending word remains deliverable.
- sin_valid gaps: any number of idle cycles between bits is legal. Partial state is held indefinitely.
- Back-to-back words with no gap are legal. Sustained throughput is one word every WIDTH cycles when q_ready is high.
- Control view: two implicit states.
  - COLLECT: bit_cnt counts 0..WIDTH-1.
  - Output register: EMPTY or FULL (q_valid).
  - No other state machine is required.

Decomposition:
- Shared package shift_reg_pkg holds:
  - bit-order constants (BIT_ORDER_MSB=1, BIT_ORDER_LSB=0)
  - a clog2-style width function for CNT_W, reused by the PISO transmitter
- One natural sub-module: pipo_hold_reg, a WIDTH-bit parallel register with load enable, async active-high rst, and a valid flag with set/clear. It is instantiated as the output stage.
- Shift register and counter stay in the top module.

Test Plan:
1. Reset: assert rst mid-word after 2 bits, asynchronously between edges -> q=0, q_valid=0, bit_cnt=0, overrun=0 before the next edge; first word after release assembles cleanly.
2. MSB_FIRST=1, WIDTH=4, q_ready=1, bits 1,0,0,1 on consecutive edges -> q=4'b1001, q_valid high exactly one cycle, starting the cycle after the 4th bit.
3. Gapped input, bits 1,idle,0,idle,1,1 -> bit_cnt sequence 0,1,1,2,2,3,0; q=4'b1011. Repeat with MSB_FIRST=0 and bits 1,1,0,0 -> q=4'b0011.
4. Backpressure, q_ready=0, send 1001 then 0110 -> q stays 1001, q_valid=1, overrun=1 after the 8th bit. One q_ready pulse -> q_valid=0. clr -> overrun=0.
5. Simultaneous events: q holds 1001 and q_ready=1 on the edge sampling the final bit of 0110 -> q=0110, q_valid stays 1, overrun stays 0.
6. clr after 2 bits, with a pending word in q: sin_valid=1 during clr -> bit_cnt=0, the bit is discarded, q and q_valid unchanged; the next 4 bits 0,1,1,1 produce q=4'b0111.
